// File: rtl/fb_vga_reader.sv
// fb_vga_reader: VGA scan-out of the 160x120 RGB565 frame buffer.
// 4x pixel/line replication, one pixel period of output latency.
module fb_vga_reader #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int CLK_DIV  = 4,
   parameter int MEM_LAT  = 1,
   parameter int IMG_W    = H_ACTIVE >> 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic        oe,
   output logic [14:0] rAddr,
   input  logic [15:0] rData,
   output logic        h_sync,
   output logic        v_sync,
   output logic        de,
   output logic [3:0]  red,
   output logic [3:0]  green,
   output logic [3:0]  blue,
   output logic        frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW = $clog2(H_TOTAL);
   localparam int VW = $clog2(V_TOTAL);
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT   = HW'(H_ACTIVE);
   localparam logic [VW-1:0] V_ACT   = VW'(V_ACTIVE);
   localparam logic [VW-1:0] V_ACTM1 = VW'(V_ACTIVE - 1);
   localparam logic [HW-1:0] HS_BEG  = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END  = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] VS_BEG  = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END  = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [DW-1:0] DIV_LST = DW'(CLK_DIV - 1);
   localparam logic [14:0]   ROW_STP = 15'(IMG_W);
   localparam logic [14:0]   COL_LST = 15'(IMG_W - 1);

   logic [DW-1:0]      div_cnt;
   logic               tick;
   logic [HW-1:0]      h;
   logic [VW-1:0]      v;
   logic [14:0]        row_base;
   logic [14:0]        col;
   logic               h_wrap;
   logic               v_wrap;
   logic               row_step;
   logic               act;
   logic               hs_n;
   logic               vs_n;
   logic [MEM_LAT-1:0] oe_pipe;
   logic [15:0]        hold;
   logic               p_de;
   logic               p_hs;
   logic               p_vs;
   logic               p_first;

   assign tick   = (div_cnt == DIV_LST);
   assign h_wrap = (h == H_LAST);
   assign v_wrap = (v == V_LAST);
   assign act    = (h < H_ACT) && (v < V_ACT);
   assign hs_n   = !((h >= HS_BEG) && (h < HS_END));
   assign vs_n   = !((v >= VS_BEG) && (v < VS_END));

   // Last stored row never advances the base, so the
   // address stays inside the image during blanking.
   assign row_step = h_wrap && (v[1:0] == 2'b11) && (v < V_ACTM1);

   // Column saturates in horizontal blanking.
   assign col   = (h < H_ACT) ? 15'(h >> 2) : COL_LST;
   assign rAddr = row_base + col;
   assign oe    = tick && act;

   // Pixel tick divider.
   always_ff @(posedge clk) begin
      if (reset) begin
         div_cnt <= '0;
      end else if (tick) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + DW'(1);
      end
   end

   // Raster counters and row base address.
   always_ff @(posedge clk) begin
      if (reset) begin
         h        <= '0;
         v        <= '0;
         row_base <= '0;
      end else if (tick) begin
         if (h_wrap) begin
            h <= '0;
            if (v_wrap) begin
               v        <= '0;
               row_base <= '0;
            end else begin
               v <= v + VW'(1);
               if (row_step) begin
                  row_base <= row_base + ROW_STP;
               end
            end
         end else begin
            h <= h + HW'(1);
         end
      end
   end

   // Track outstanding reads to know when rData is valid.
   always_ff @(posedge clk) begin
      if (reset) begin
         oe_pipe <= '0;
      end else begin
         oe_pipe <= (oe_pipe << 1) | MEM_LAT'(oe);
      end
   end

   // Capture the returned word for the output stage.
   always_ff @(posedge clk) begin
      if (reset) begin
         hold <= '0;
      end else if (oe_pipe[MEM_LAT-1]) begin
         hold <= rData;
      end
   end

   // Timing of the pixel whose read is in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         p_de    <= 1'b0;
         p_hs    <= 1'b1;
         p_vs    <= 1'b1;
         p_first <= 1'b0;
      end else if (tick) begin
         p_de    <= act;
         p_hs    <= hs_n;
         p_vs    <= vs_n;
         p_first <= (h == '0) && (v == '0);
      end
   end

   // Output stage: timing and colour leave together.
   always_ff @(posedge clk) begin
      if (reset) begin
         de     <= 1'b0;
         h_sync <= 1'b1;
         v_sync <= 1'b1;
         red    <= 4'h0;
         green  <= 4'h0;
         blue   <= 4'h0;
      end else if (tick) begin
         de     <= p_de;
         h_sync <= p_hs;
         v_sync <= p_vs;
         red    <= p_de ? hold[15:12] : 4'h0;
         green  <= p_de ? hold[10:7]  : 4'h0;
         blue   <= p_de ? hold[4:1]   : 4'h0;
      end
   end

   // Single-clock marker as pixel (0,0) appears.
   always_ff @(posedge clk) begin
      if (reset) begin
         frame_start <= 1'b0;
      end else begin
         frame_start <= tick && p_first;
      end
   end

endmodule

// File: tb/tb_fb_vga_reader.sv
// tb_fb_vga_reader: full-size and reduced-raster instances
// checked against a pixel-index model of the scan-out.
module tb_fb_vga_reader;

   typedef struct packed {
      int ha; int hfp; int hsw; int hbp;
      int va; int vfp; int vsw; int vbp;
      int div;
   } cfg_t;

   typedef struct {
      logic [15:0] w;
      logic [3:0]  r;
      logic [3:0]  g;
      logic [3:0]  b;
   } vec_t;

   localparam cfg_t CF = '{ha:640, hfp:16, hsw:96, hbp:48,
                           va:480, vfp:10, vsw:2, vbp:33,
                           div:4};
   localparam cfg_t CS = '{ha:16, hfp:2, hsw:3, hbp:3,
                           va:12, vfp:1, vsw:2, vbp:2,
                           div:4};

   logic clk = 1'b0;
   logic reset = 1'b1;

   logic        oe_f, hs_f, vs_f, de_f, fs_f;
   logic [14:0] ra_f;
   logic [15:0] rd_f;
   logic [3:0]  r_f, g_f, b_f;

   logic        oe_s, hs_s, vs_s, de_s, fs_s;
   logic [14:0] ra_s;
   logic [15:0] rd_s;
   logic [3:0]  r_s, g_s, b_s;

   logic [15:0] mem_f [0:19199];
   logic [15:0] mem_s [0:11];

   int checks = 0;
   int errors = 0;
   int k = 0;
   int a_f, a_s;

   int qde_r[$], qde_f[$], qhs_f[$], qhs_r[$];
   int qvs_f[$], qvs_r[$], qfs_f[$], qfs_s[$];
   logic de_fp = 1'b0, hs_fp = 1'b1, vs_sp = 1'b1;

   vec_t tab [6];

   always #5 clk = ~clk;

   fb_vga_reader u_full (
      .clk(clk), .reset(reset),
      .oe(oe_f), .rAddr(ra_f), .rData(rd_f),
      .h_sync(hs_f), .v_sync(vs_f), .de(de_f),
      .red(r_f), .green(g_f), .blue(b_f),
      .frame_start(fs_f)
   );

   fb_vga_reader #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(12), .V_FP(1), .V_SYNC(2), .V_BP(2),
      .CLK_DIV(4), .MEM_LAT(1), .IMG_W(4)
   ) u_small (
      .clk(clk), .reset(reset),
      .oe(oe_s), .rAddr(ra_s), .rData(rd_s),
      .h_sync(hs_s), .v_sync(vs_s), .de(de_s),
      .red(r_s), .green(g_s), .blue(b_s),
      .frame_start(fs_s)
   );

   // Frame buffer models: one clock read latency.
   always @(posedge clk) begin
      if (oe_f && ra_f < 15'd19200) rd_f <= mem_f[ra_f];
      if (oe_s && ra_s < 15'd12) rd_s <= mem_s[ra_s[3:0]];
   end

   // Cycle index since the last reset edge (1 = first cycle after it).
   always @(posedge clk) k <= reset ? 1 : k + 1;

   // Raster position and image address of pixel number n.
   function automatic void geom(input cfg_t c, input int n,
                                output bit act, output bit hs,
                                output bit vs, output int addr);
      int ht, vt, h, v;
      ht = c.ha + c.hfp + c.hsw + c.hbp;
      vt = c.va + c.vfp + c.vsw + c.vbp;
      h = n % ht;
      v = (n / ht) % vt;
      act = (h < c.ha) && (v < c.va);
      hs = !(h >= c.ha + c.hfp && h < c.ha + c.hfp + c.hsw);
      vs = !(v >= c.va + c.vfp && v < c.va + c.vfp + c.vsw);
      addr = (v / 4) * (c.ha / 4) + h / 4;
   endfunction

   // Address of the pixel on the outputs in cycle kk, or -1.
   function automatic int out_addr(input cfg_t c, input int kk);
      bit act, hs, vs;
      int a, t;
      t = (kk - 1) / c.div;
      if (t < 2) return -1;
      geom(c, t - 2, act, hs, vs, a);
      return act ? a : -1;
   endfunction

   task automatic chk(input string nm, input cfg_t c, input int kk,
                      input logic [15:0] w, input logic oe,
                      input logic [14:0] ra, input logic hs,
                      input logic vs, input logic de,
                      input logic [3:0] r, input logic [3:0] g,
                      input logic [3:0] b, input logic fs,
                      input int maxa);
      bit act, ehs, evs;
      int ea, pa, t, n, fr;
      logic e_oe, e_de, e_hs, e_vs, e_fs;
      logic [3:0] er, eg, eb;
      logic [16:0] ev, av;
      fr = (c.ha + c.hfp + c.hsw + c.hbp) *
           (c.va + c.vfp + c.vsw + c.vbp);
      e_oe = 1'b0;
      ea = 0;
      if (kk % c.div == 0) begin
         geom(c, kk / c.div - 1, act, ehs, evs, ea);
         e_oe = act;
      end
      e_de = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_fs = 1'b0;
      er = 4'h0; eg = 4'h0; eb = 4'h0;
      t = (kk - 1) / c.div;
      if (t >= 2) begin
         n = t - 2;
         geom(c, n, act, ehs, evs, pa);
         e_de = act;
         e_hs = ehs;
         e_vs = evs;
         if (act) begin
            er = w[15:12];
            eg = w[10:7];
            eb = w[4:1];
         end
         e_fs = ((kk - 1) % c.div == 0) && (n % fr == 0);
      end
      ev = {e_oe, e_de, e_hs, e_vs, er, eg, eb, e_fs};
      av = {oe, de, hs, vs, r, g, b, fs};
      checks++;
      if (av !== ev) begin
         errors++;
         $display("FAIL %s outputs k=%0d got %h want %h",
                  nm, kk, av, ev);
      end
      if (e_oe) begin
         checks++;
         if (ra !== 15'(ea)) begin
            errors++;
            $display("FAIL %s addr k=%0d got %0d want %0d",
                     nm, kk, ra, ea);
         end
      end
      checks++;
      if (ra > maxa) begin
         errors++;
         $display("FAIL %s addr_range k=%0d got %0d max %0d",
                  nm, kk, ra, maxa);
      end
   endtask

   // Every cycle: compare both instances against the model.
   always @(negedge clk) begin
      if (k >= 1) begin
         a_f = out_addr(CF, k);
         a_s = out_addr(CS, k);
         chk("full", CF, k, (a_f >= 0) ? mem_f[15'(a_f)] : 16'h0,
             oe_f, ra_f, hs_f, vs_f, de_f, r_f, g_f, b_f, fs_f,
             19199);
         chk("small", CS, k, (a_s >= 0) ? mem_s[4'(a_s)] : 16'h0,
             oe_s, ra_s, hs_s, vs_s, de_s, r_s, g_s, b_s, fs_s, 11);
      end
   end

   // Edge log for line/frame timing checks.
   always @(negedge clk) begin
      if (k >= 1) begin
         if (de_f && !de_fp) qde_r.push_back(k);
         if (!de_f && de_fp) qde_f.push_back(k);
         if (!hs_f && hs_fp) qhs_f.push_back(k);
         if (hs_f && !hs_fp) qhs_r.push_back(k);
         if (!vs_s && vs_sp) qvs_f.push_back(k);
         if (vs_s && !vs_sp) qvs_r.push_back(k);
         if (fs_f) qfs_f.push_back(k);
         if (fs_s) qfs_s.push_back(k);
      end
      de_fp <= de_f;
      hs_fp <= hs_f;
      vs_sp <= vs_s;
   end

   task automatic expect_int(input string nm, input int got,
                             input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s got %0d want %0d", nm, got, want);
      end
   endtask

   task wait_k(input int target);
      int n;
      n = 0;
      while (k != target && n < 30000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (k != target) begin
         errors++;
         $display("FAIL wait_k got %0d want %0d", k, target);
      end
   endtask

   task first_read(input string nm);
      int n;
      n = 0;
      while (!oe_f && n < 20) begin
         @(negedge clk);
         n++;
      end
      expect_int({nm, "_tick_clk"}, k, 4);
      expect_int({nm, "_addr"}, int'(ra_f), 0);
   endtask

   function automatic int qget(input int q[$], input int i);
      return (q.size() > i) ? q[i] : -1;
   endfunction

   initial begin
      tab[0] = '{16'hF81F, 4'hF, 4'h0, 4'hF};
      tab[1] = '{16'h07E0, 4'h0, 4'hF, 4'h0};
      tab[2] = '{16'hFFFF, 4'hF, 4'hF, 4'hF};
      tab[3] = '{16'h0000, 4'h0, 4'h0, 4'h0};
      tab[4] = '{16'h8421, 4'h8, 4'h8, 4'h0};
      tab[5] = '{16'h1234, 4'h1, 4'h4, 4'hA};
      for (int i = 0; i < 19200; i++) mem_f[i] = 16'($urandom);
      for (int i = 0; i < 12; i++) mem_s[i] = 16'($urandom);
      for (int i = 0; i < 6; i++) mem_f[i] = tab[i].w;

      reset = 1'b1;
      repeat (10) @(posedge clk);
      #1 reset = 1'b0;

      first_read("start");

      for (int i = 0; i < 6; i++) begin
         wait_k(4 * (4 * i + 2) + 1);
         checks++;
         if ({de_f, r_f, g_f, b_f} !==
             {1'b1, tab[i].r, tab[i].g, tab[i].b}) begin
            errors++;
            $display("FAIL colour[%0d] got %h want %h", i,
                     {de_f, r_f, g_f, b_f},
                     {1'b1, tab[i].r, tab[i].g, tab[i].b});
         end
      end

      wait_k(10806);
      expect_int("de_rise0", qget(qde_r, 0), 9);
      expect_int("de_fall0", qget(qde_f, 0), 9 + 2560);
      expect_int("hs_fall0", qget(qhs_f, 0), 9 + 2624);
      expect_int("hs_rise0", qget(qhs_r, 0), 9 + 2624 + 384);
      expect_int("de_rise1", qget(qde_r, 1), 9 + 3200);
      expect_int("fs_full_n", qfs_f.size(), 1);
      expect_int("fs_full0", qget(qfs_f, 0), 9);
      expect_int("fs_small0", qget(qfs_s, 0), 9);
      expect_int("fs_small1", qget(qfs_s, 1), 9 + 1632);
      expect_int("vs_fall0", qget(qvs_f, 0), 1257);
      expect_int("vs_rise0", qget(qvs_r, 0), 1257 + 192);

      @(posedge clk);
      #1 reset = 1'b1;
      qfs_f.delete();
      qfs_s.delete();
      @(posedge clk);
      #1 reset = 1'b0;

      first_read("rst");
      wait_k(4000);
      expect_int("rst_fs_full_n", qfs_f.size(), 1);
      expect_int("rst_fs_full0", qget(qfs_f, 0), 9);
      expect_int("rst_fs_small_n", qfs_s.size(), 3);
      expect_int("rst_fs_small1", qget(qfs_s, 1), 9 + 1632);
      expect_int("rst_fs_small2", qget(qfs_s, 2), 9 + 2 * 1632);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
